alu_sweep_checker: RTL and testbench

ALU_SWEEP_CHECKER -- requirements
Module: alu_sweep_checker

---
 rtl/alu_sweep_checker.sv | 144 ++++++++++++++
 tb/tb_alu_sweep_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_checker.sv
// Sweeps all 32 {Mode, A, B, Select} vectors into a 1-bit ALU and checks each response.
// Optional build macro ALU_CHECK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module alu_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [1:0] Select,
    output logic       Mode,
    output logic       A,
    output logic       B,
    input  logic       Output,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [5:0] ErrCount,
    output logic [4:0] FirstFailIdx,
    output logic       FailValid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [5:0] ERR_MAX   = 6'd32;

    state_t     state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [3:0] wait_q, wait_d;
    logic [5:0] err_q, err_d;
    logic [4:0] ffi_q, ffi_d;
    logic       fv_q, fv_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch;
    logic       last_vec;

    // Reference response; the vector register doubles as the sweep index.
    function automatic logic golden(input logic [4:0] v);
        logic       m, a, b, aop;
        logic [1:0] sel;
        {m, a, b, sel} = v;
        aop = a ^ sel[0];
        if (!m) golden = (sel[1] ? (a ^ b) : a) ^ sel[0];
        else    golden = sel[1] ? (aop & b) : (aop ^ b);
    endfunction

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wait_d   = wait_q;
        err_d    = err_q;
        ffi_d    = ffi_q;
        fv_d     = fv_q;
        mismatch = (Output != golden(vec_q));
        last_vec = (vec_q == 5'd31);
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        last_vec = last_vec || mismatch;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_DRIVE;
                    vec_d   = 5'd0;
                    err_d   = 6'd0;
                    ffi_d   = 5'd0;
                    fv_d    = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) state_d = ST_SAMPLE;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 6'd1;
                    if (!fv_q) begin
                        ffi_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end
                if (last_vec) begin
                    state_d = ST_DONE;
                    vec_d   = 5'd0;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Done/Pass publish one cycle after DONE entry, once the last compare has landed in ErrCount.
    always_comb begin
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        pass_d = done_d && (err_q == 6'd0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            vec_q   <= 5'd0;
            wait_q  <= 4'd0;
            err_q   <= 6'd0;
            ffi_q   <= 5'd0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign {Mode, A, B, Select} = vec_q;
    assign Busy         = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign ErrCount     = err_q;
    assign FirstFailIdx = ffi_q;
    assign FailValid    = fv_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: a SETTLE_CYCLES=2 instance and a SETTLE_CYCLES=0 instance,
// each fed by a bench-side ALU that can be correct, stuck at 0, or inverted.
module tb_alu_sweep_checker;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       fv;
        logic [5:0] err;
        logic [4:0] ffi;
        logic [4:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic [1:0] sel_a, sel_b;
    logic mode_a, mode_b, a_a, a_b, b_a, b_b, out_a, out_b;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
    logic [5:0] err_a, err_b;
    logic [4:0] ffi_a, ffi_b;

    int fault_a = 0, fault_b = 0;
    bit act_a = 0, act_b = 0;
    int st_a = 0, st_b = 0;
    int cyc = 0;
    int compared = 0, mismatched = 0;
    int lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU written from the operation table with integer arithmetic.
    function automatic logic alu_ref(input logic [4:0] v);
        int m, a, b, sel, x, s;
        m = v[4]; a = v[3]; b = v[2]; sel = v[1:0];
        if (m == 0) begin
            case (sel)
                0: return a == 1;
                1: return a == 0;
                2: return a != b;
                default: return a == b;
            endcase
        end
        x = (sel % 2 == 1) ? 1 - a : a;
        s = x + b;
        return (sel >= 2) ? (s >= 2) : (s % 2 == 1);
    endfunction

    function automatic logic alu_seen(input int fault, input logic [4:0] v);
        if (fault == 1) return 1'b0;
        if (fault == 2) return ~alu_ref(v);
        return alu_ref(v);
    endfunction

    // Expected outputs n edges after the edge that accepted Start.
    function automatic exp_t expect_at(input int fault, input int s, input int n);
        exp_t e;
        int per, err, ffi, nvec, fin;
        bit fv;
        per = s + 2; err = 0; ffi = 0; fv = 0; nvec = 32;
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        for (int k = 31; k >= 0; k--)
            if (alu_seen(fault, 5'(k)) != alu_ref(5'(k))) nvec = k + 1;
`endif
        for (int k = 0; k < nvec; k++) begin
            if ((k + 1) * per <= n && alu_seen(fault, 5'(k)) != alu_ref(5'(k))) begin
                err++;
                if (!fv) begin ffi = k; fv = 1; end
            end
        end
        fin    = nvec * per;
        e.busy = (n < fin);
        e.vec  = e.busy ? 5'(n / per) : 5'd0;
        e.done = (n >= fin + 1);
        e.pass = e.done && (err == 0);
        e.fv   = fv;
        e.err  = 6'(err);
        e.ffi  = 5'(ffi);
        return e;
    endfunction

    assign out_a = alu_seen(fault_a, {mode_a, a_a, b_a, sel_a});
    assign out_b = alu_seen(fault_b, {mode_b, a_b, b_b, sel_b});

    alu_sweep_checker #(.SETTLE_CYCLES(2)) dut_a (
        .Clk(clk), .Reset(rst), .Start(start_a), .Select(sel_a), .Mode(mode_a), .A(a_a), .B(b_a),
        .Output(out_a), .Busy(busy_a), .Done(done_a), .Pass(pass_a), .ErrCount(err_a),
        .FirstFailIdx(ffi_a), .FailValid(fv_a)
    );

    alu_sweep_checker #(.SETTLE_CYCLES(0)) dut_b (
        .Clk(clk), .Reset(rst), .Start(start_b), .Select(sel_b), .Mode(mode_b), .A(a_b), .B(b_b),
        .Output(out_b), .Busy(busy_b), .Done(done_b), .Pass(pass_b), .ErrCount(err_b),
        .FirstFailIdx(ffi_b), .FailValid(fv_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic busy, input logic done,
                       input logic pass, input logic fv, input logic [5:0] err,
                       input logic [4:0] ffi, input logic [4:0] vec);
        chk({tag, "_busy"}, busy, e.busy);
        chk({tag, "_done"}, done, e.done);
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_failvalid"}, fv, e.fv);
        chk({tag, "_errcount"}, err, e.err);
        chk({tag, "_firstfail"}, ffi, e.ffi);
        chk({tag, "_vector"}, vec, e.vec);
    endtask

    always @(negedge clk) begin
        if (act_a)
            cmp("s2", expect_at(fault_a, 2, cyc - st_a), busy_a, done_a, pass_a, fv_a, err_a,
                ffi_a, {mode_a, a_a, b_a, sel_a});
        if (act_b)
            cmp("s0", expect_at(fault_b, 0, cyc - st_b), busy_b, done_b, pass_b, fv_b, err_b,
                ffi_b, {mode_b, a_b, b_b, sel_b});
    end

    task automatic do_start(input int inst);
        @(negedge clk);
        if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (inst == 0) begin st_a = cyc; act_a = 1; end
        else begin st_b = cyc; act_b = 1; end
    endtask

    task automatic wait_done(input int inst, input int repulse_n, output int l);
        int n;
        logic d;
        l = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            d = (inst == 0) ? done_a : done_b;
            n = cyc - ((inst == 0) ? st_a : st_b);
            if (d) begin
                l = n;
                break;
            end
            if (n == repulse_n) begin
                if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
                @(posedge clk);
                #1;
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        if (l < 0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        act_a = 0;
        act_b = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_errcount"}, err_a, 0);
        chk({tag, "_firstfail"}, ffi_a, 0);
        chk({tag, "_failvalid"}, fv_a, 0);
        chk({tag, "_vector"}, {mode_a, a_a, b_a, sel_a}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_b_busy", busy_b, 0);
        rst = 1'b0;

        // Correct ALU, Start re-pulsed during vector 5.
        fault_a = 0;
        do_start(0);
        wait_done(0, 21, lat);
        chk("good_latency", lat, 129);
        chk("good_err", err_a, 0);
        chk("good_pass", pass_a, 1);
        chk("good_fv", fv_a, 0);

        // Output stuck at 0.
        fault_a = 1;
        do_start(0);
        wait_done(0, -1, lat);
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        chk("stuck_latency", lat, 9);
        chk("stuck_err", err_a, 1);
`else
        chk("stuck_latency", lat, 129);
        chk("stuck_err", err_a, 14);
`endif
        chk("stuck_ffi", ffi_a, 1);
        chk("stuck_fv", fv_a, 1);
        chk("stuck_pass", pass_a, 0);

        // Inverted output.
        fault_a = 2;
        do_start(0);
        wait_done(0, -1, lat);
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        chk("inv_err", err_a, 1);
`else
        chk("inv_err", err_a, 32);
`endif
        chk("inv_ffi", ffi_a, 0);
        chk("inv_pass", pass_a, 0);

        // Reset during WAIT of vector 10, then a clean sweep.
        fault_a = 0;
        do_start(0);
        while (cyc - st_a < 41) @(negedge clk);
        chk("pre_reset_vector", {mode_a, a_a, b_a, sel_a}, 10);
        act_a = 0;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        do_start(0);
        wait_done(0, -1, lat);
        chk("post_reset_latency", lat, 129);
        chk("post_reset_pass", pass_a, 1);

        // Zero settle time.
        fault_b = 0;
        do_start(1);
        wait_done(1, -1, lat);
        chk("s0_latency", lat, 65);
        chk("s0_pass", pass_b, 1);
        fault_b = 1;
        do_start(1);
        wait_done(1, -1, lat);
        chk("s0_stuck_ffi", ffi_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
